data_mem: RTL



---
 rtl/data_mem_pkg.sv | 37 +++
 rtl/data_mem_if.sv | 21 ++
 rtl/data_mem_lane_merge.sv | 25 ++
 rtl/data_mem.sv | 71 +++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared MIPS encodings for the data memory and the controller: store/load codes,
// memory depth and the alignment rules for each access type.
package mips_defs;

    localparam int DM_WORDS = 3072;

    typedef enum logic [1:0] {
        STORE_SW  = 2'd0,
        STORE_SB  = 2'd1,
        STORE_SH  = 2'd2,
        STORE_RSV = 2'd3
    } store_t;

    typedef enum logic [2:0] {
        LOAD_LW = 3'd0,
        LOAD_LB = 3'd1,
        LOAD_LH = 3'd2
    } load_t;

    function automatic logic store_misaligned(input logic [1:0] st, input logic [1:0] lane);
        case (st)
            STORE_SW: return lane != 2'b00;
            STORE_SH: return lane[0];
            default:  return 1'b0;
        endcase
    endfunction

    // Unknown load codes behave as lw, so they carry the word alignment rule.
    function automatic logic load_misaligned(input logic [2:0] lt, input logic [1:0] lane);
        case (lt)
            LOAD_LB: return 1'b0;
            LOAD_LH: return lane[0];
            default: return lane != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_if.sv
// Datapath-to-data-memory access bus; the datapath is the master.
interface data_mem_if;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        DM_enable;
    logic [1:0]  store_type;
    logic [2:0]  load_type;
    logic [31:0] rdata;
    logic        align_err;

    modport master (
        output pc, addr, wdata, DM_enable, store_type, load_type,
        input  rdata, align_err
    );

    modport slave (
        input  pc, addr, wdata, DM_enable, store_type, load_type,
        output rdata, align_err
    );
endinterface

// File: rtl/data_mem_lane_merge.sv
// Merges store data into the old memory word according to store type and byte lane.
module dm_lane_merge
    import mips_defs::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  store_type,
    input  logic [1:0]  lane,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        case (store_type)
            STORE_SW: merged = wdata;
            STORE_SH: begin
                if (lane[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            STORE_SB: merged[{lane, 3'b000} +: 8] = wdata[7:0];
            default:  merged = old_word;
        endcase
    end

endmodule

// File: rtl/data_mem.sv
// Word-organised data memory: synchronous lane-merged stores, combinational
// extracting/sign-extending loads, and a log line for every committed write.
module data_mem
    import mips_defs::*;
#(
    parameter int WORDS = DM_WORDS
) (
    input logic        clk,
    input logic        reset,
    data_mem_if.slave  bus
);

    localparam int IDX_W = $clog2(WORDS);

    logic [31:0]      mem [WORDS];
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             in_range;
    logic             ld_misaligned;
    logic             commit;
    logic [31:0]      cur_word;
    logic [31:0]      merged;

    assign idx      = bus.addr[IDX_W+1:2];
    assign lane     = bus.addr[1:0];
    assign in_range = {2'b00, bus.addr[31:2]} < 32'(WORDS);
    assign cur_word = in_range ? mem[idx] : 32'h0;

    assign ld_misaligned = load_misaligned(bus.load_type, lane);
    assign bus.align_err = bus.DM_enable ? store_misaligned(bus.store_type, lane)
                                         : ld_misaligned;

    assign commit = bus.DM_enable && !reset && (bus.store_type != STORE_RSV)
                    && in_range && !bus.align_err;

    dm_lane_merge u_merge (
        .old_word   (cur_word),
        .wdata      (bus.wdata),
        .store_type (bus.store_type),
        .lane       (lane),
        .merged     (merged)
    );

    always_comb begin
        bus.rdata = 32'h0;
        if (in_range && !ld_misaligned) begin
            case (bus.load_type)
                LOAD_LB: bus.rdata = {{24{cur_word[{lane, 3'b111}]}}, cur_word[{lane, 3'b000} +: 8]};
                LOAD_LH: bus.rdata = lane[1] ? {{16{cur_word[31]}}, cur_word[31:16]}
                                             : {{16{cur_word[15]}}, cur_word[15:0]};
                default: bus.rdata = cur_word;
            endcase
        end
    end

    // Reset wipes every word and wins over a store in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= 32'h0;
        end else if (commit) begin
            mem[idx] <= merged;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (commit) $display("@%h: *%h <= %h", bus.pc, {bus.addr[31:2], 2'b00}, merged);
    end
`endif

endmodule
